sb_rx_framer: RTL and testbench

- Sideband receive front end for the logical layer; sits directly upstream of the logical layer's sideband transaction handler.
- Deserializes the single-wire `sbrx` line into 10-bit characters: start bit 0, 8 data bits LSB first, stop bit 1.
- Strips USB4 DLE framing and DLE stuffing, then delivers payload bytes with start/end/error markers.
- Runs entirely in the sideband clock domain: one bit per `sb_clk` cycle.

---
 rtl/sb_rx_framer.sv | 130 +++++++++++++
 tb/tb_sb_rx_framer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sb_rx_framer.sv
// sb_rx_framer: sideband serial deserializer and DLE deframer delivering payload bytes
module sb_rx_framer #(
  parameter logic [7:0] DLE     = 8'hFE,
  parameter logic [7:0] ETX     = 8'h40,
  parameter int         MAX_LEN = 64
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       sbrx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       rx_sof,
  output logic [7:0] rx_stx,
  output logic       rx_eof,
  output logic       rx_frame_err,
  output logic       rx_busy
);
  localparam int LW = $clog2(MAX_LEN + 1);
  typedef enum logic [1:0] {C_IDLE, C_DATA, C_STOP} cstate_t;
  typedef enum logic [1:0] {F_IDLE, F_DLE, F_BODY, F_BODY_DLE} fstate_t;
  logic s1, s;
  cstate_t cs, cs_n;
  logic [2:0] cnt;
  logic [7:0] sh;
  logic char_valid, char_err;
  fstate_t fs, fs_n;
  logic [LW-1:0] len;
  logic sof_arm, emit, eof, err, start;
  // two-flop synchronizer; presets to idle-high so reset never fakes a start bit
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s  <= 1'b1;
    end else begin
      s1 <= sbrx;
      s  <= s1;
    end
  end
  // character FSM next state: start bit, eight data bits, stop bit
  always_comb begin
    cs_n = (cs == C_IDLE) ? (s ? C_IDLE : C_DATA) :
           (cs == C_DATA) ? ((cnt == 3'd7) ? C_STOP : C_DATA) : C_IDLE;
  end
  // character register: sh stays stable through the char_valid cycle since the next data bit lands later
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      cs         <= C_IDLE;
      cnt        <= 3'd0;
      sh         <= 8'd0;
      char_valid <= 1'b0;
      char_err   <= 1'b0;
    end else begin
      cs         <= cs_n;
      cnt        <= (cs == C_DATA) ? cnt + 3'd1 : 3'd0;
      if (cs == C_DATA) sh[cnt] <= s;
      char_valid <= (cs == C_STOP) && s;
      char_err   <= (cs == C_STOP) && !s;
    end
  end
  // frame FSM next state and per-character actions; length overflow overrides an emit
  always_comb begin
    fs_n  = fs;
    emit  = 1'b0;
    eof   = 1'b0;
    err   = 1'b0;
    start = 1'b0;
    case (fs)
      F_IDLE: if (char_valid && sh == DLE) fs_n = F_DLE;
      F_DLE: begin
        if (char_err || (char_valid && (sh == DLE || sh == ETX))) fs_n = F_IDLE;
        else if (char_valid) begin
          start = 1'b1;
          fs_n  = F_BODY;
        end
      end
      F_BODY: begin
        if (char_err) begin
          err  = 1'b1;
          fs_n = F_IDLE;
        end else if (char_valid) begin
          if (sh == DLE) fs_n = F_BODY_DLE;
          else emit = 1'b1;
        end
      end
      F_BODY_DLE: begin
        if (char_err || (char_valid && sh != DLE && sh != ETX)) begin
          err  = 1'b1;
          fs_n = F_IDLE;
        end else if (char_valid && sh == ETX) begin
          eof  = 1'b1;
          fs_n = F_IDLE;
        end else if (char_valid) begin
          emit = 1'b1;
          fs_n = F_BODY;
        end
      end
    endcase
    if (emit && len == LW'(MAX_LEN)) begin
      emit = 1'b0;
      err  = 1'b1;
      fs_n = F_IDLE;
    end
  end
  // frame state and registered outputs
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      fs            <= F_IDLE;
      len           <= '0;
      sof_arm       <= 1'b0;
      rx_byte       <= 8'd0;
      rx_byte_valid <= 1'b0;
      rx_sof        <= 1'b0;
      rx_stx        <= 8'd0;
      rx_eof        <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      fs            <= fs_n;
      len           <= start ? '0 : emit ? len + LW'(1) : len;
      sof_arm       <= start | (sof_arm & ~emit);
      rx_byte_valid <= emit;
      rx_sof        <= emit & sof_arm;
      if (emit) rx_byte <= sh;
      if (start) rx_stx <= sh;
      rx_eof        <= eof;
      rx_frame_err  <= err;
      rx_busy       <= (fs_n == F_BODY) || (fs_n == F_BODY_DLE);
    end
  end
endmodule

// File: tb/tb_sb_rx_framer.sv
// tb_sb_rx_framer: directed frames checked every cycle against a byte-level deframing model
module tb_sb_rx_framer;
  localparam logic [7:0] DLE = 8'hFE;
  localparam logic [7:0] ETX = 8'h40;
  localparam int ML = 4;
  logic clk = 1'b0, rst = 1'b1, sbrx = 1'b1;
  logic [7:0] rx_byte, rx_stx;
  logic rx_byte_valid, rx_sof, rx_eof, rx_frame_err, rx_busy;
  always #5 clk = ~clk;
  sb_rx_framer #(.MAX_LEN(ML)) dut (
    .sb_clk(clk), .rst(rst), .sbrx(sbrx), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .rx_sof(rx_sof), .rx_stx(rx_stx), .rx_eof(rx_eof), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );
  typedef struct {
    int t;
    logic v, sof, eof, err, busy;
    logic [7:0] b, stx;
  } ev_t;
  ev_t q[$];
  int cyc = 0, errors = 0, checks = 0;
  int n_sof = 0, n_eof = 0, n_err = 0;
  logic [7:0] got[$];
  logic [7:0] fr[$];
  logic chk_en = 1'b0, exp_busy = 1'b0;
  logic [7:0] exp_stx = 8'd0;
  logic m_in = 1'b0, m_pend = 1'b0, m_first = 1'b0;
  logic [7:0] m_stx = 8'd0;
  int m_n = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, g, e);
    end
  endtask
  function automatic void push_ev(int t, logic v, logic sof, logic eof, logic err, logic [7:0] b);
    ev_t e;
    e.t = t; e.v = v; e.sof = sof; e.eof = eof; e.err = err; e.b = b;
    e.busy = m_in; e.stx = m_stx;
    q.push_back(e);
  endfunction
  function automatic void model_emit(logic [7:0] b, int t);
    if (m_n == ML) begin
      m_in = 0; m_pend = 0;
      push_ev(t, 0, 0, 0, 1, 0);
    end else begin
      push_ev(t, 1, m_first, 0, 0, b);
      m_first = 0;
      m_n++;
    end
  endfunction
  function automatic void model_char(logic [7:0] c, bit bad, int t);
    if (bad) begin
      if (m_in) begin
        m_in = 0;
        push_ev(t, 0, 0, 0, 1, 0);
      end
      m_pend = 0;
    end else if (!m_in) begin
      if (m_pend) begin
        m_pend = 0;
        if (c != DLE && c != ETX) begin
          m_in = 1; m_n = 0; m_first = 1; m_stx = c;
          push_ev(t, 0, 0, 0, 0, 0);
        end
      end else m_pend = (c == DLE);
    end else if (m_pend) begin
      m_pend = 0;
      if (c == DLE) model_emit(8'hFE, t);
      else begin
        m_in = 0;
        push_ev(t, 0, 0, c == ETX, c != ETX, 0);
      end
    end else if (c == DLE) m_pend = 1;
    else model_emit(c, t);
  endfunction
  always @(negedge clk) begin
    ev_t e;
    if (chk_en) begin
      if (q.size() > 0 && q[0].t == cyc) begin
        e = q.pop_front();
        exp_busy = e.busy;
        exp_stx = e.stx;
      end else begin
        e.t = cyc; e.v = 0; e.sof = 0; e.eof = 0; e.err = 0; e.b = 0;
        e.busy = exp_busy; e.stx = exp_stx;
      end
      chk("outputs", {19'd0, rx_byte_valid, rx_sof, rx_eof, rx_frame_err, rx_busy, rx_stx},
          {19'd0, e.v, e.sof, e.eof, e.err, e.busy, e.stx});
      if (e.v) chk("rx_byte", {24'd0, rx_byte}, {24'd0, e.b});
      if (rx_byte_valid) got.push_back(rx_byte);
      n_sof += int'(rx_sof);
      n_eof += int'(rx_eof);
      n_err += int'(rx_frame_err);
    end
  end
  task automatic send_bit(input logic b);
    @(negedge clk);
    sbrx = b;
  endtask
  task automatic send_char(input logic [7:0] c, input bit bad = 0, input int gap = 1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(c[i]);
    @(negedge clk);
    sbrx = !bad;
    model_char(c, bad, cyc + 4);
    repeat (gap) send_bit(1'b1);
  endtask
  task automatic send_fr(input int gap);
    foreach (fr[i]) send_char(fr[i], 0, gap);
  endtask
  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask
  task automatic obs(input string nm, input int nb, input logic [31:0] bs, input int ns, input int ne, input int nr);
    chk({nm, ".nbytes"}, got.size(), nb);
    for (int i = 0; i < nb && i < got.size(); i++) chk({nm, ".byte"}, {24'd0, got[i]}, {24'd0, bs[8*i +: 8]});
    chk({nm, ".sof"}, n_sof, ns);
    chk({nm, ".eof"}, n_eof, ne);
    chk({nm, ".err"}, n_err, nr);
    got.delete();
    n_sof = 0; n_eof = 0; n_err = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1; sbrx = 1;
    q.delete();
    exp_busy = 0; exp_stx = 0;
    m_in = 0; m_pend = 0; m_stx = 0;
    @(negedge clk);
    #1;
    chk("rst.outputs", {11'd0, rx_byte_valid, rx_sof, rx_eof, rx_frame_err, rx_busy, rx_stx, rx_byte}, 32'd0);
    rst = 0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset.outputs", {11'd0, rx_byte_valid, rx_sof, rx_eof, rx_frame_err, rx_busy, rx_stx, rx_byte}, 32'd0);
    @(negedge clk);
    rst = 0;
    chk_en = 1;
    idle(4);
    fr = '{DLE, 8'h05, 8'hA5, 8'h3C, DLE, ETX};
    send_fr(1);
    idle(8);
    obs("t1", 2, 32'h0000_3CA5, 1, 1, 0);
    chk("t1.stx", {24'd0, rx_stx}, 32'h05);
    fr = '{DLE, 8'h05, 8'hFE, 8'hFE, 8'h11, DLE, ETX};
    send_fr(0);
    idle(8);
    obs("t2", 2, 32'h0000_11FE, 1, 1, 0);
    send_char(DLE); send_char(8'h05); send_char(8'h22);
    send_char(8'h33, 1);
    send_char(8'h44); send_char(DLE); send_char(ETX);
    idle(6);
    chk("t3.busy_after_err", {31'd0, rx_busy}, 32'd0);
    fr = '{DLE, 8'h07, 8'h55, DLE, ETX};
    send_fr(1);
    idle(8);
    obs("t3", 2, 32'h0000_5522, 2, 1, 1);
    chk("t3.stx", {24'd0, rx_stx}, 32'h07);
    fr = '{DLE, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, DLE, ETX};
    send_fr(1);
    idle(8);
    obs("t4", 4, 32'h0403_0201, 1, 0, 1);
    fr = '{DLE, 8'h05, DLE, ETX};
    send_fr(1);
    idle(8);
    obs("t5a", 0, 32'd0, 0, 1, 0);
    fr = '{DLE, 8'h06, DLE, 8'h77};
    send_fr(1);
    idle(8);
    obs("t5b", 0, 32'd0, 0, 0, 1);
    send_char(DLE); send_char(8'h05); send_char(8'h10);
    send_bit(1'b0);
    repeat (5) send_bit(1'b0);
    do_reset();
    idle(4);
    fr = '{DLE, 8'h05, 8'h9A, DLE, ETX};
    send_fr(1);
    idle(8);
    obs("t6", 2, 32'h0000_9A10, 2, 1, 0);
    chk("t6.stx", {24'd0, rx_stx}, 32'h05);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
